btb_nbit_predictor: RTL and testbench

- Parametrised branch target buffer with N-bit saturating direction counters.
- Successor to the 8-entry 1-bit BHT in the NPC path.
- Fetch side: combinational lookup of the IF-stage PC, returning hit, direction, target and predicted next PC.
- Execute side: resolved branches update counters and targets, and allocate entries with round-robin replacement.

---
 rtl/btb_nbit_predictor.sv | 161 ++++++++++++++++
 tb/tb_btb_nbit_predictor.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_nbit_predictor.sv
// Fully associative branch target buffer with CTR_W-bit saturating direction counters.
// Latency: lookup is combinational (0 cycles); updates, allocation and flush commit on the next clk edge.
// Backpressure: none; one lookup and one resolved-branch update are accepted every cycle.
// Optional feature macro: BTB_STATS_EN adds saturating branch/mispredict statistics counters.
module btb_nbit_predictor #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CTR_W   = 2
) (
    input  logic             clk,
    input  logic             CpuRst_n,
    input  logic [31:0]      lookup_pc,
    output logic             lookup_hit,
    output logic             lookup_taken,
    output logic [31:0]      lookup_target,
    output logic [31:0]      lookup_npc,
    output logic [IDX_W-1:0] lookup_index,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_hit,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_mispred,
`ifdef BTB_STATS_EN
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispreds,
`endif
    input  logic             flush
);

    // Counter constants: saturation limit, unit step and the weakly-taken allocation value.
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Table storage; tags hold the full PC so aliasing is impossible.
    logic [ENTRIES-1:0] valid_q;
    logic [31:0]        tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr_q;

    // Lookup-side match results.
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    // Update-side decode.
    logic             upd_confirm;
    logic             upd_alloc;
    logic             any_invalid;
    logic [IDX_W-1:0] first_invalid;
    logic [IDX_W-1:0] victim;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_inc;
    logic [CTR_W-1:0] ctr_dec;

    // Associative match on the IF-stage PC; the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == lookup_pc)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Fetch-side outputs derived from the matched entry (pre-edge state, no update bypass).
    always_comb begin
        lookup_hit    = hit;
        lookup_index  = hit_idx;
        lookup_target = hit ? target_q[hit_idx] : 32'h0;
        lookup_taken  = hit & ctr_q[hit_idx][CTR_W-1];
        lookup_npc    = lookup_taken ? lookup_target : (lookup_pc + 32'd4);
    end

    // Find the lowest-index invalid entry as the preferred allocation victim.
    always_comb begin
        any_invalid   = 1'b0;
        first_invalid = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!any_invalid && !valid_q[i]) begin
                any_invalid   = 1'b1;
                first_invalid = IDX_W'(i);
            end
        end
    end

    // Classify the resolved branch: confirm a carried hit, or allocate on a taken miss.
    // A carried hit whose entry was since replaced or flushed is treated as a miss.
    always_comb begin
        upd_confirm = upd_valid & upd_hit & valid_q[upd_index]
                      & (tag_q[upd_index] == upd_pc);
        upd_alloc   = upd_valid & ~upd_confirm & upd_taken;
        victim      = any_invalid ? first_invalid : rr_ptr_q;
    end

    // Saturating counter step values for the confirmed entry.
    always_comb begin
        ctr_cur = ctr_q[upd_index];
        ctr_inc = (ctr_cur == CTR_MAX)  ? ctr_cur : (ctr_cur + CTR_ONE);
        ctr_dec = (ctr_cur == CTR_ZERO) ? ctr_cur : (ctr_cur - CTR_ONE);
    end

    // Table state: reset clears everything, flush drops only valid bits, otherwise apply the update.
    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (upd_confirm) begin
            if (upd_taken) begin
                ctr_q[upd_index]    <= ctr_inc;
                target_q[upd_index] <= upd_target;
            end else begin
                ctr_q[upd_index]    <= ctr_dec;
            end
        end else if (upd_alloc) begin
            valid_q[victim]  <= 1'b1;
            tag_q[victim]    <= upd_pc;
            target_q[victim] <= upd_target;
            ctr_q[victim]    <= CTR_INIT;
            // Round-robin only moves when a live entry is evicted.
            if (!any_invalid) begin
                rr_ptr_q <= rr_ptr_q + IDX_ONE;
            end
        end
    end

`ifdef BTB_STATS_EN
    // Saturating resolved-branch and mispredict counters; only reset clears them.
    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            stat_branches <= '0;
            stat_mispreds <= '0;
        end else begin
            if (upd_valid && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (upd_valid && upd_mispred && (stat_mispreds != 32'hFFFF_FFFF)) begin
                stat_mispreds <= stat_mispreds + 32'd1;
            end
        end
    end
`else
    // Mispredict flag only feeds the statistics counters.
    logic unused_mispred;
    assign unused_mispred = upd_mispred;
`endif

endmodule

// File: tb/tb_btb_nbit_predictor.sv
// Self-checking bench for btb_nbit_predictor: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: lookup outputs compared combinationally before each edge; model state advances at each edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_btb_nbit_predictor;

    localparam int N     = 8;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CINIT = 1 << (CW - 1);

    logic        clk;
    logic        CpuRst_n;
    logic [31:0] lookup_pc;
    logic        lookup_hit;
    logic        lookup_taken;
    logic [31:0] lookup_target;
    logic [31:0] lookup_npc;
    logic [2:0]  lookup_index;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_hit;
    logic [2:0]  upd_index;
    logic        upd_mispred;
    logic        flush;
`ifdef BTB_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispreds;
`endif

    btb_nbit_predictor #(.ENTRIES(N), .CTR_W(CW)) dut (
        .clk          (clk),
        .CpuRst_n     (CpuRst_n),
        .lookup_pc    (lookup_pc),
        .lookup_hit   (lookup_hit),
        .lookup_taken (lookup_taken),
        .lookup_target(lookup_target),
        .lookup_npc   (lookup_npc),
        .lookup_index (lookup_index),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_hit      (upd_hit),
        .upd_index    (upd_index),
        .upd_mispred  (upd_mispred),
`ifdef BTB_STATS_EN
        .stat_branches(stat_branches),
        .stat_mispreds(stat_mispreds),
`endif
        .flush        (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: plain arrays and integer counters.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_rr;
    int          m_br;
    int          m_mp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 0;
        end
        m_rr = 0;
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit h, output int idx,
                            output bit tk, output logic [31:0] tg, output logic [31:0] np);
        h = 0; idx = 0; tk = 0; tg = 0;
        // scan downward so the lowest matching index is the one left standing
        for (int i = N - 1; i >= 0; i--) begin
            if (m_valid[i] && m_tag[i] == pc) begin
                h = 1;
                idx = i;
            end
        end
        if (h) begin
            tg = m_tgt[idx];
            tk = (m_ctr[idx] >= CINIT);
        end
        np = tk ? tg : pc + 32'd4;
    endtask

    task automatic m_apply(input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                           input bit uh, input int uidx, input bit um, input bit fl);
        int  v;
        bit  found;
        if (uv) begin
            m_br++;
            if (um) m_mp++;
        end
        if (fl) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else if (uv) begin
            if (uh && m_valid[uidx] && m_tag[uidx] == upc) begin
                if (ut) begin
                    m_ctr[uidx] = (m_ctr[uidx] + 1 > CMAX) ? CMAX : m_ctr[uidx] + 1;
                    m_tgt[uidx] = utgt;
                end else begin
                    m_ctr[uidx] = (m_ctr[uidx] - 1 < 0) ? 0 : m_ctr[uidx] - 1;
                end
            end else if (ut) begin
                found = 0;
                v = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && !m_valid[i]) begin
                        found = 1;
                        v = i;
                    end
                end
                if (!found) begin
                    v = m_rr;
                    m_rr = (m_rr + 1) % N;
                end
                m_valid[v] = 1;
                m_tag[v]   = upc;
                m_tgt[v]   = utgt;
                m_ctr[v]   = CINIT;
            end
        end
    endtask

    task automatic check_outputs(input string nm);
        bit h, tk;
        int idx;
        logic [31:0] tg, np;
        m_lookup(lookup_pc, h, idx, tk, tg, np);
        chk({nm, "_hit"},    32'(lookup_hit),    32'(h));
        chk({nm, "_taken"},  32'(lookup_taken),  32'(tk));
        chk({nm, "_target"}, lookup_target,      tg);
        chk({nm, "_npc"},    lookup_npc,         np);
        chk({nm, "_index"},  32'(lookup_index),  32'(idx));
    endtask

    // One clock cycle: apply inputs, compare lookup against the model, then advance the model at the edge.
    task automatic drive(input logic [31:0] lpc, input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit uh, input logic [2:0] uidx,
                         input bit um, input bit fl);
        lookup_pc   = lpc;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_taken   = ut;
        upd_target  = utgt;
        upd_hit     = uh;
        upd_index   = uidx;
        upd_mispred = um;
        flush       = fl;
        #2;
        check_outputs("cyc");
        @(posedge clk);
        m_apply(uv, upc, ut, utgt, uh, int'(uidx), um, fl);
        #1;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt);
        drive(32'h0, 1, pc, 1, tgt, 0, 3'd0, 0, 0);
    endtask

    task automatic confirm(input logic [31:0] pc, input logic [2:0] idx, input bit tk, input logic [31:0] tgt);
        drive(32'h0, 1, pc, tk, tgt, 1, idx, 0, 0);
    endtask

    // Idle cycle that checks the lookup of pc against hand-derived constants and the model.
    task automatic dexp(input string nm, input logic [31:0] pc, input bit eh, input int eidx,
                        input bit etk, input logic [31:0] enpc);
        lookup_pc = pc;
        upd_valid = 0;
        flush     = 0;
        #2;
        chk({nm, "_hit"},   32'(lookup_hit),   32'(eh));
        chk({nm, "_index"}, 32'(lookup_index), 32'(eidx));
        chk({nm, "_taken"}, 32'(lookup_taken), 32'(etk));
        chk({nm, "_npc"},   lookup_npc,        enpc);
        check_outputs(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit h, tk;
        int idx;
        logic [31:0] tg, np, lpc, upc;
        bit uh;
        logic [2:0] uidx;

        CpuRst_n = 0;
        lookup_pc = 32'h100;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_hit = 0; upd_index = 0; upd_mispred = 0; flush = 0;
        m_reset();
        #1;
        chk("rst_hit",    32'(lookup_hit),   32'd0);
        chk("rst_taken",  32'(lookup_taken), 32'd0);
        chk("rst_target", lookup_target,     32'h0);
        chk("rst_index",  32'(lookup_index), 32'd0);
        chk("rst_npc",    lookup_npc,        32'h104);
        @(posedge clk);
        #1;
        CpuRst_n = 1;

        // Taken miss allocates weakly taken into index 0.
        alloc(32'h100, 32'h200);
        dexp("alloc", 32'h100, 1, 0, 1, 32'h200);

        // Counter hysteresis.
        confirm(32'h100, 3'd0, 0, 32'h0);
        dexp("nt1", 32'h100, 1, 0, 0, 32'h104);
        confirm(32'h100, 3'd0, 0, 32'h0);
        dexp("nt2", 32'h100, 1, 0, 0, 32'h104);
        confirm(32'h100, 3'd0, 1, 32'h200);
        dexp("t1", 32'h100, 1, 0, 0, 32'h104);
        confirm(32'h100, 3'd0, 1, 32'h200);
        dexp("t2", 32'h100, 1, 0, 1, 32'h200);
        for (int i = 0; i < 4; i++) confirm(32'h100, 3'd0, 1, 32'h200);
        confirm(32'h100, 3'd0, 0, 32'h0);
        dexp("sat1", 32'h100, 1, 0, 1, 32'h200);
        confirm(32'h100, 3'd0, 0, 32'h0);
        dexp("sat2", 32'h100, 1, 0, 0, 32'h104);

        // Fill then round-robin replacement.
        drive(32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 1);
        for (int i = 0; i < 8; i++) alloc(32'(4 * i), 32'h800 + 32'(4 * i));
        alloc(32'h40, 32'h900);
        alloc(32'h44, 32'h904);
        dexp("rep00", 32'h00, 0, 0, 0, 32'h4);
        dexp("rep40", 32'h40, 1, 0, 1, 32'h900);
        dexp("rep44", 32'h44, 1, 1, 1, 32'h904);
        dexp("rep08", 32'h08, 1, 2, 1, 32'h808);

        // Stale carried index after flush becomes a fresh allocation.
        drive(32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 1);
        alloc(32'h10, 32'h1);
        alloc(32'h14, 32'h2);
        alloc(32'h18, 32'h3);
        alloc(32'h100, 32'h200);
        dexp("stl_pre", 32'h100, 1, 3, 1, 32'h200);
        drive(32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 1);
        drive(32'h0, 1, 32'h100, 1, 32'h500, 1, 3'd3, 0, 0);
        dexp("stl_new", 32'h100, 1, 0, 1, 32'h500);
        confirm(32'h100, 3'd0, 0, 32'h0);
        dexp("stl_ctr", 32'h100, 1, 0, 0, 32'h104);

        // Same-cycle lookup and allocate of one PC: new entry visible only next cycle.
        lookup_pc = 32'h300; upd_valid = 1; upd_pc = 32'h300; upd_taken = 1;
        upd_target = 32'h700; upd_hit = 0; upd_index = 0; upd_mispred = 0; flush = 0;
        #2;
        chk("same_hit_now", 32'(lookup_hit), 32'd0);
        @(posedge clk);
        m_apply(1, 32'h300, 1, 32'h700, 0, 0, 0, 0);
        #1;
        dexp("same_next", 32'h300, 1, 1, 1, 32'h700);

        // Flush wins over a concurrent update.
        drive(32'h0, 1, 32'h400, 1, 32'h900, 0, 3'd0, 0, 1);
        dexp("fl_400", 32'h400, 0, 0, 0, 32'h404);
        dexp("fl_300", 32'h300, 0, 0, 0, 32'h304);
        dexp("fl_100", 32'h100, 0, 0, 0, 32'h104);

        // npc wraps modulo 2^32.
        dexp("wrap", 32'hFFFF_FFFC, 0, 0, 0, 32'h0);

        // Asynchronous reset mid-operation drops outputs before any clock edge.
        alloc(32'h120, 32'h620);
        upd_valid = 0;
        lookup_pc = 32'h120;
        #1;
        chk("arst_pre_hit", 32'(lookup_hit), 32'd1);
        CpuRst_n = 0;
        #1;
        chk("arst_hit", 32'(lookup_hit), 32'd0);
        chk("arst_npc", lookup_npc, 32'h124);
        m_reset();
        check_outputs("arst");
        @(posedge clk);
        #1;
        CpuRst_n = 1;

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            lpc = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'h1000 + 32'(4 * $urandom_range(0, 11));
            upc = 32'h1000 + 32'(4 * $urandom_range(0, 11));
            m_lookup(upc, h, idx, tk, tg, np);
            if ($urandom_range(0, 3) != 0) begin
                uh   = h;
                uidx = 3'(idx);
            end else begin
                uh   = 1'($urandom_range(0, 1));
                uidx = 3'($urandom_range(0, 7));
            end
            drive(lpc, 1'($urandom_range(0, 2) != 0), upc, 1'($urandom_range(0, 1)),
                  32'h4000 + 32'(4 * $urandom_range(0, 255)), uh, uidx,
                  1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
        end

`ifdef BTB_STATS_EN
        chk("stat_branches", stat_branches, 32'(m_br));
        chk("stat_mispreds", stat_mispreds, 32'(m_mp));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
